// File: rtl/spmv_csr_mac_engine_pkg.sv
// Shared definitions for the row-serial CSR SpMV engine: state encodings,
// default widths and slicing helpers for the packed row_ptr / x buses.
package spmv_csr_mac_engine_pkg;

   localparam int N_ROWS_DEF = 16;
   localparam int DW_DEF     = 16;
   localparam int ACC_W_DEF  = 40;
   localparam int RP_W       = 8;
   localparam int COL_W      = 4;
   localparam int N_COLS     = 16;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_LOAD  = 4'd1,
      S_MAC   = 4'd2,
      S_WRITE = 4'd3,
      S_DONE  = 4'd6
   } state_t;

   function automatic logic [RP_W-1:0] rp_entry(input logic [255:0] rp, input logic [4:0] idx);
      return rp[idx*RP_W +: RP_W];
   endfunction

   function automatic logic [DW_DEF-1:0] vec_elem(input logic [255:0] vec, input logic [3:0] idx);
      return vec[idx*DW_DEF +: DW_DEF];
   endfunction

endpackage

// File: rtl/spmv_csr_mac_engine_mac.sv
// Signed multiply-accumulate: full-precision DW x DW product, sign-extended
// into a wrapping ACC_W accumulator with synchronous clear and enable.
module spmv_mac_unit
   import spmv_csr_mac_engine_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic signed [DW-1:0]    i_a,
   input  logic signed [DW-1:0]    i_b,
   output logic signed [ACC_W-1:0] o_acc
);

   logic signed [2*DW-1:0]  w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] r_acc;

   assign w_prod     = i_a * i_b;
   assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

   // Clear wins over enable; the controller never asserts both.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/spmv_csr_mac_engine.sv
// Row-serial CSR y = A*x engine: walks each row's nonzeros through the MAC
// unit and hands one accumulated result per row out over valid/ready.
module spmv_csr_mac_engine
   import spmv_csr_mac_engine_pkg::*;
#(
   parameter int N_ROWS = N_ROWS_DEF,
   parameter int DW     = DW_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_start,
   input  logic                    i_clear,
   input  logic [255:0]            i_row_ptr,
   input  logic [COL_W-1:0]        i_col_idx,
   input  logic signed [DW-1:0]    i_val,
   input  logic [255:0]            i_vec,
   output logic [7:0]              o_count,
   output logic                    o_y_valid,
   input  logic                    i_y_ready,
   output logic [3:0]              o_y_row,
   output logic signed [ACC_W-1:0] o_y_data,
   output logic [3:0]              o_state,
   output logic                    o_err,
   output logic                    o_done
);

   logic [RP_W-1:0]      w_rp [0:N_ROWS];
   logic signed [DW-1:0] w_x  [0:N_COLS-1];

   genvar gi;
   generate
      for (gi = 0; gi <= N_ROWS; gi++) begin : g_rp
         assign w_rp[gi] = rp_entry(i_row_ptr, 5'(gi));
      end
      for (gi = 0; gi < N_COLS; gi++) begin : g_vec
         assign w_x[gi] = vec_elem(i_vec, 4'(gi));
      end
   endgenerate

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_row, w_row_nxt;
   logic [7:0]      r_count, w_count_nxt;
   logic [7:0]      r_end, w_end_nxt;
   logic            r_err, w_err_nxt;
   logic            w_acc_clr;
   logic            w_acc_en;
   logic [RP_W-1:0] w_start_ptr;
   logic [RP_W-1:0] w_end_ptr;
   logic signed [ACC_W-1:0] w_acc;

   assign w_start_ptr = w_rp[{1'b0, r_row}];
   assign w_end_ptr   = w_rp[{1'b0, r_row} + 5'd1];

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_count_nxt = r_count;
      w_end_nxt   = r_end;
      w_err_nxt   = r_err;
      w_acc_clr   = 1'b0;
      w_acc_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_row_nxt   = '0;
            w_count_nxt = '0;
            w_acc_clr   = 1'b1;
            if (i_start) begin
               w_err_nxt   = 1'b0;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_count_nxt = w_start_ptr;
            w_end_nxt   = w_end_ptr;
            w_acc_clr   = 1'b1;
            // A backwards pointer pair is flagged and the row is emitted as 0.
            if (w_end_ptr > w_start_ptr) begin
               w_state_nxt = S_MAC;
            end else begin
               w_state_nxt = S_WRITE;
               if (w_end_ptr < w_start_ptr) begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_MAC: begin
            w_acc_en = 1'b1;
            if (r_count == r_end - 8'd1) begin
               w_state_nxt = S_WRITE;
            end else begin
               w_count_nxt = r_count + 8'd1;
            end
         end
         S_WRITE: begin
            if (i_y_ready) begin
               if (r_row == 4'(N_ROWS-1)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_row_nxt   = r_row + 4'd1;
                  w_state_nxt = S_LOAD;
               end
            end
         end
         S_DONE: begin
            if (i_clear) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_count <= '0;
         r_end   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_count <= w_count_nxt;
         r_end   <= w_end_nxt;
         r_err   <= w_err_nxt;
      end
   end

   spmv_mac_unit #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_clr  (w_acc_clr),
      .i_en   (w_acc_en),
      .i_a    (i_val),
      .i_b    (w_x[i_col_idx]),
      .o_acc  (w_acc)
   );

   assign o_count   = r_count;
   assign o_y_valid = (r_state == S_WRITE);
   assign o_y_row   = r_row;
   assign o_y_data  = w_acc;
   assign o_state   = r_state;
   assign o_err     = r_err;
   assign o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_spmv_csr_mac_engine.sv
// Self-checking bench for spmv_csr_mac_engine: table-driven matrix scenarios,
// hand-written control sequences and randomized matrices against a CSR model.
module tb_spmv_csr_mac_engine;

   logic               clk = 1'b0;
   logic               rstn;
   logic               start;
   logic               clear;
   logic               ready;
   logic [255:0]       row_ptr;
   logic [255:0]       vec;
   logic [3:0]         col_idx;
   logic signed [15:0] val;
   logic [7:0]         o_count;
   logic               o_y_valid;
   logic [3:0]         o_y_row;
   logic signed [39:0] o_y_data;
   logic [3:0]         o_state;
   logic               o_err;
   logic               o_done;

   always #5 clk = ~clk;

   // Upstream stores seen by the engine
   int                 rp [17];
   logic [3:0]         colm [256];
   logic signed [15:0] valm [256];
   logic signed [15:0] xv [16];

   always_comb begin
      row_ptr = '0;
      vec     = '0;
      for (int i = 0; i < 17; i++) row_ptr[i*8 +: 8] = rp[i][7:0];
      for (int i = 0; i < 16; i++) vec[i*16 +: 16] = xv[i];
   end

   assign col_idx = colm[o_count];
   assign val     = valm[o_count];

   spmv_csr_mac_engine dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_start   (start),
      .i_clear   (clear),
      .i_row_ptr (row_ptr),
      .i_col_idx (col_idx),
      .i_val     (val),
      .i_vec     (vec),
      .o_count   (o_count),
      .o_y_valid (o_y_valid),
      .i_y_ready (ready),
      .o_y_row   (o_y_row),
      .o_y_data  (o_y_data),
      .o_state   (o_state),
      .o_err     (o_err),
      .o_done    (o_done)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: y[r] = sum of val*x[col] over [rp[r], rp[r+1]), mod 2^40
   logic [39:0] exp_y [16];
   bit          exp_err;
   int          exp_cycles;

   task automatic model();
      exp_err    = 1'b0;
      exp_cycles = 0;
      for (int r = 0; r < 16; r++) begin
         longint s = 0;
         if (rp[r+1] < rp[r]) exp_err = 1'b1;
         for (int k = rp[r]; k < rp[r+1]; k++)
            s += longint'(valm[k]) * longint'(xv[colm[k]]);
         exp_y[r] = s[39:0];
         exp_cycles += 2 + ((rp[r+1] > rp[r]) ? (rp[r+1] - rp[r]) : 0);
      end
   endtask

   task automatic setup(input int kind);
      for (int k = 0; k < 256; k++) begin
         colm[k] = '0;
         valm[k] = '0;
      end
      case (kind)
         0: begin
            for (int i = 0; i < 17; i++) rp[i] = i;
            for (int k = 0; k < 256; k++) begin colm[k] = 4'(k % 16); valm[k] = 16'sd1; end
            for (int c = 0; c < 16; c++) xv[c] = 16'(c);
         end
         1: begin
            for (int i = 0; i < 17; i++) rp[i] = 0;
            for (int c = 0; c < 16; c++) xv[c] = 16'($urandom());
            for (int k = 0; k < 256; k++) valm[k] = 16'($urandom());
         end
         2: begin
            rp[0] = 0;
            for (int i = 1; i < 17; i++) rp[i] = 16;
            for (int k = 0; k < 16; k++) begin colm[k] = 4'(k); valm[k] = -16'sd3; end
            for (int c = 0; c < 16; c++) xv[c] = 16'sd1000;
         end
         3: begin
            for (int i = 0; i < 17; i++) rp[i] = (i <= 5) ? 2 * i : 4;
            for (int k = 0; k < 256; k++) begin colm[k] = 4'(k % 16); valm[k] = 16'sd1; end
            for (int c = 0; c < 16; c++) xv[c] = 16'(c);
         end
         default: begin
            rp[0] = 0;
            for (int r = 0; r < 16; r++) rp[r+1] = rp[r] + int'($urandom_range(0, 8));
            for (int k = 0; k < 256; k++) begin colm[k] = 4'($urandom()); valm[k] = 16'($urandom()); end
            for (int c = 0; c < 16; c++) xv[c] = 16'($urandom());
         end
      endcase
   endtask

   logic [39:0] got_y [16];
   int          got_row [16];
   int          last_cycles;

   task automatic run(input string tag, input int stall_row, input int stall_len,
                      input bit rnd_ready, input bit chk_cycles, input int restart_at);
      int          n, idx, stall_cnt;
      bit          pend;
      logic [3:0]  snap_row;
      logic [39:0] snap_y;
      logic [7:0]  snap_cnt;
      model();
      for (int i = 0; i < 16; i++) begin got_y[i] = 'x; got_row[i] = -1; end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, "_err_cleared"}, 64'(o_err), 64'd0);
      n = 0; idx = 0; stall_cnt = 0; pend = 1'b0;
      snap_row = '0; snap_y = '0; snap_cnt = '0;
      while (!o_done && n < 3000) begin
         start = (n == restart_at);
         if (stall_row >= 0 && o_y_valid && int'(o_y_row) == stall_row && stall_cnt < stall_len) begin
            ready = 1'b0;
            stall_cnt++;
         end else if (rnd_ready) begin
            ready = ($urandom_range(0, 2) != 0);
         end else begin
            ready = 1'b1;
         end
         if (o_y_valid && pend) begin
            chk({tag, "_hold_row"}, 64'(o_y_row), 64'(snap_row));
            chk({tag, "_hold_data"}, {24'b0, o_y_data}, {24'b0, snap_y});
            chk({tag, "_hold_count"}, 64'(o_count), 64'(snap_cnt));
         end
         pend     = o_y_valid && !ready;
         snap_row = o_y_row;
         snap_y   = o_y_data;
         snap_cnt = o_count;
         if (o_y_valid && ready) begin
            $display("%s: row %0d y=%0d", tag, o_y_row, o_y_data);
            if (idx < 16) begin got_y[idx] = o_y_data; got_row[idx] = int'(o_y_row); end
            idx++;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      ready = 1'b1;
      last_cycles = n;
      chk({tag, "_done"}, 64'(o_done), 64'd1);
      chk({tag, "_nresults"}, 64'(idx), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s_row%0d_idx", tag, i), 64'(got_row[i]), 64'(i));
         chk($sformatf("%s_row%0d_y", tag, i), {24'b0, got_y[i]}, {24'b0, exp_y[i]});
      end
      chk({tag, "_err"}, 64'(o_err), 64'(exp_err));
      if (chk_cycles)
         chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles + ((stall_row >= 0) ? stall_len : 0)));
      if (!o_done) begin
         rstn = 1'b0;
         @(negedge clk);
         rstn = 1'b1;
      end
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   typedef struct {
      string       name;
      int          kind;
      logic [39:0] y0;
      logic [39:0] y5;
      bit          err;
      int          cycles;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int n;
      tbl[0].name = "identity";  tbl[0].kind = 0; tbl[0].y0 = 40'd0;        tbl[0].y5 = 40'd5; tbl[0].err = 0; tbl[0].cycles = 48;
      tbl[1].name = "empty";     tbl[1].kind = 1; tbl[1].y0 = 40'd0;        tbl[1].y5 = 40'd0; tbl[1].err = 0; tbl[1].cycles = 32;
      tbl[2].name = "dense_neg"; tbl[2].kind = 2; tbl[2].y0 = 40'(-48000);  tbl[2].y5 = 40'd0; tbl[2].err = 0; tbl[2].cycles = 48;
      tbl[3].name = "malformed"; tbl[3].kind = 3; tbl[3].y0 = 40'd1;        tbl[3].y5 = 40'd0; tbl[3].err = 1; tbl[3].cycles = 42;

      rstn = 1'b0; start = 1'b0; clear = 1'b0; ready = 1'b1;
      setup(0);
      repeat (3) @(negedge clk);
      chk("reset_state", 64'(o_state), 64'd0);
      chk("reset_count", 64'(o_count), 64'd0);
      chk("reset_valid", 64'(o_y_valid), 64'd0);
      chk("reset_data", {24'b0, o_y_data}, 64'd0);
      chk("reset_done", 64'(o_done), 64'd0);
      rstn = 1'b1;

      for (int t = 0; t < 4; t++) begin
         setup(tbl[t].kind);
         run(tbl[t].name, -1, 0, 1'b0, 1'b1, -1);
         chk({tbl[t].name, "_tbl_y0"}, {24'b0, got_y[0]}, {24'b0, tbl[t].y0});
         chk({tbl[t].name, "_tbl_y5"}, {24'b0, got_y[5]}, {24'b0, tbl[t].y5});
         chk({tbl[t].name, "_tbl_err"}, 64'(o_err), 64'(tbl[t].err));
         chk({tbl[t].name, "_tbl_cycles"}, 64'(last_cycles), 64'(tbl[t].cycles));
         do_clear();
         chk({tbl[t].name, "_idle_state"}, 64'(o_state), 64'd0);
         chk({tbl[t].name, "_idle_err"}, 64'(o_err), 64'(tbl[t].err));
      end

      // start while in DONE must be ignored
      setup(0);
      run("done_start", -1, 0, 1'b0, 1'b1, -1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("done_ignores_start", 64'(o_state), 64'd6);
      do_clear();

      setup(0);
      run("backpressure", 3, 5, 1'b0, 1'b1, -1);
      do_clear();

      setup(2);
      run("start_in_mac", -1, 0, 1'b0, 1'b1, 3);
      do_clear();

      // Asynchronous reset during row 7's MAC cycle
      setup(0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!(o_state == 4'd1 && o_y_row == 4'd7) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("midrun_in_mac", 64'(o_state), 64'd2);
      chk("midrun_row", 64'(o_y_row), 64'd7);
      rstn = 1'b0;
      #1;
      chk("midrun_rst_state", 64'(o_state), 64'd0);
      chk("midrun_rst_count", 64'(o_count), 64'd0);
      chk("midrun_rst_valid", 64'(o_y_valid), 64'd0);
      chk("midrun_rst_row", 64'(o_y_row), 64'd0);
      chk("midrun_rst_data", {24'b0, o_y_data}, 64'd0);
      chk("midrun_rst_done", 64'(o_done), 64'd0);
      chk("midrun_rst_err", 64'(o_err), 64'd0);
      @(negedge clk); rstn = 1'b1;
      run("after_reset", -1, 0, 1'b0, 1'b1, -1);
      do_clear();

      for (int i = 0; i < 6; i++) begin
         setup(4);
         run($sformatf("random%0d", i), -1, 0, (i % 2 == 1), (i % 2 == 0), -1);
         do_clear();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spmv_csr_mac_engine.md
# spmv_csr_mac_engine

Row-serial CSR multiply-accumulate stage that consumes the row-pointer buffer and count-indexed column index produced by the SRAM1 reader, together with a count-indexed nonzero value stream and a dense 16-entry input vector, and produces y = A·x one row at a time. It drives the shared `count` index back to the reader and value stores, walks each row's nonzeros, and emits one accumulated result per row over a valid/ready handshake to the result writer.

## Interface
- `N_ROWS`, 16: matrix rows processed per run; row_ptr entries 0..N_ROWS are used.
- `DW`, 16: width of values and vector elements, signed two's complement.
- `ACC_W`, 40: accumulator / result width.
- `i_clk` in 1: single clock, rising edge.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle pulse, begin a run; sampled only in IDLE.
- `i_clear` in 1: return from DONE to IDLE.
- `i_row_ptr` in 256: CSR row pointers, entry r at bits [8r +: 8], unsigned.
- `i_col_idx` in 4: column of nonzero `o_count`, combinational from `o_count`.
- `i_val` in DW: value of nonzero `o_count`, combinational from `o_count`.
- `i_vec` in 256: x vector, element c at bits [16c +: 16].
- `o_count` out 8: nonzero index driven to upstream stores.
- `o_y_valid` out 1: result valid.
- `i_y_ready` in 1: result writer accepts.
- `o_y_row` out 4: row of current result.
- `o_y_data` out ACC_W: row result, signed.
- `o_state` out 4: current state encoding.
- `o_err` out 1: sticky malformed-row_ptr flag.
- `o_done` out 1: high while in DONE.

## Operation
- States: IDLE=0, LOAD=1, MAC=2, WRITE=3, DONE=6; undefined encodings go to IDLE.
- IDLE: holds row=0, acc=0, o_count=0, o_err=0 (cleared on i_start); i_start -> LOAD.
- LOAD: start=row_ptr[row], end=row_ptr[row+1]; o_count<=start; acc<=0; if end>start -> MAC else -> WRITE (empty row, y=0). If end<start: set o_err, treat as empty.
- MAC: each cycle acc += sext(i_val*x[i_col_idx]) (signed DW×DW → 2·DW, sign-extended to ACC_W, wraps modulo 2^ACC_W); o_count increments; when o_count==end-1 the last product is added and -> WRITE.
- WRITE: o_y_valid=1, o_y_row=row, o_y_data=acc held stable until i_y_ready. On accept: if row==N_ROWS-1 -> DONE, else row+1 -> LOAD.
- DONE: o_done=1; i_clear -> IDLE; i_start ignored.
- i_start outside IDLE ignored; i_clear outside DONE ignored.
- o_count never wraps: row_ptr entries are 8-bit so end ≤ 255.

## Timing
- Reset (async): state=IDLE, o_count=0, o_y_valid=0, o_y_row=0, o_y_data=0, o_err=0, o_done=0, o_state=0.
- i_col_idx/i_val must be valid in the same cycle as o_count (combinational upstream); no read latency is absorbed here.
- Per row: 1 LOAD + nnz MAC + ≥1 WRITE cycles; empty row = 2 cycles with ready held high.
- Full run with ready tied high: 2·N_ROWS + total_nnz cycles from i_start to DONE entry.
- o_y_valid rises the cycle after the last MAC (or after LOAD for empty rows); deasserts the cycle after the accepted handshake.
- Reset mid-run aborts immediately; any pending o_y_valid drops without handshake.

## Structure
- Shared package: state encodings, N_ROWS/DW/ACC_W defaults, row_ptr entry width (8), helper for row_ptr/vec slicing.
- One natural sub-module: `spmv_mac_unit` (signed multiply, sign-extend, accumulate with clear/enable).

## Test plan
- Identity: row_ptr=0,1,…,16, col_idx[k]=k, val=1, x[c]=c -> y[r]=r for r=0..15, 48 cycles to DONE.
- Empty rows: row_ptr all 0 -> sixteen results of 0, o_err=0, DONE after 32 cycles.
- Signed/dense row: row 0 has 16 nonzeros val=-3, x all 1000, others empty -> y[0]=-48000, y[1..15]=0.
- Backpressure: i_y_ready low 5 cycles on row 3 -> o_y_valid/o_y_row/o_y_data held stable, o_count frozen, no row skipped.
- Malformed: row_ptr[5]=10, row_ptr[6]=4 -> y[5]=0, o_err=1 until next i_start.
- Control: i_start during MAC ignored; i_rstn low mid-row 7 -> all outputs to reset values; new run completes correctly.
